onehot_alloc_sched: RTL

Allocation scheduler for the 15-line binary-to-one-hot encoder datapath. It arbitrates NREQ requesters, each asking for one of NRES one-hot resource lines by binary index, using round-robin priority. It tracks which lines are currently held, and drives the encoder's valid/index inputs with the granted index one cycle after acceptance. It sits between the requesting agents and the encoder, and owns the busy/free state of every decoded line.

---
 rtl/onehot_alloc_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/onehot_alloc_sched.sv
// Round-robin allocation scheduler for the one-hot encoder lines.
// Tracks held lines and drives the encoder one cycle after a request is consumed.
module onehot_alloc_sched #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 4,
  parameter int NRES  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IDX_W-1:0]  req_idx,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   rel_valid,
  input  logic [IDX_W-1:0]       rel_idx,
  output logic                   enc_in_valid,
  output logic [IDX_W-1:0]       enc_in,
  output logic                   gnt_valid,
  output logic [2:0]             gnt_id,
  output logic                   gnt_err,
  output logic                   rel_err,
  output logic [NRES-1:0]        busy
);

  localparam int PTR_W = 3;
  localparam logic [IDX_W:0] NRES_L = (IDX_W+1)'(NRES);

  // Out-of-range indices never match a line, so they read as not busy.
  function automatic logic line_busy(input logic [NRES-1:0] mask, input logic [IDX_W-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NRES; i++) begin
      hit = hit | (mask[i] & (idx == IDX_W'(i)));
    end
    return hit;
  endfunction

  function automatic logic [NRES-1:0] line_mask(input logic [IDX_W-1:0] idx);
    logic [NRES-1:0] m;
    m = {NRES{1'b0}};
    for (int i = 0; i < NRES; i++) begin
      m[i] = (idx == IDX_W'(i));
    end
    return m;
  endfunction

  logic [NRES-1:0]  busy_r;
  logic [PTR_W-1:0] ptr_r;
  logic             enc_valid_r;
  logic [IDX_W-1:0] enc_idx_r;
  logic             gnt_valid_r;
  logic [PTR_W-1:0] gnt_id_r;
  logic             gnt_err_r;
  logic             rel_err_r;

  logic [NREQ-1:0]  elig_s;
  logic             win_found_s;
  logic [PTR_W-1:0] win_id_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_oor_s;
  logic             rel_hit_s;
  logic [NRES-1:0]  busy_nxt_s;
  logic [PTR_W-1:0] ptr_nxt_s;

  // Eligibility uses the registered busy mask only; a same-cycle release does not help.
  always_comb begin
    elig_s = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      elig_s[k] = req_valid[k] & ~line_busy(busy_r, req_idx[k*IDX_W +: IDX_W]);
    end
  end

  // Two passes: requesters at or above ptr first, then the wrapped-around low ones.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {PTR_W{1'b0}};
    win_idx_s   = {IDX_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found_s && elig_s[k] && (PTR_W'(k) >= ptr_r)) begin
        win_found_s = 1'b1;
        win_id_s    = PTR_W'(k);
        win_idx_s   = req_idx[k*IDX_W +: IDX_W];
      end else begin
        win_found_s = win_found_s;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found_s && elig_s[k]) begin
        win_found_s = 1'b1;
        win_id_s    = PTR_W'(k);
        win_idx_s   = req_idx[k*IDX_W +: IDX_W];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot ready for the winner, suppressed while reset is held.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = rst & win_found_s & (win_id_s == PTR_W'(k));
    end
  end

  // Next busy mask and round-robin pointer.
  always_comb begin
    win_oor_s  = ({1'b0, win_idx_s} >= NRES_L);
    rel_hit_s  = rel_valid & line_busy(busy_r, rel_idx);
    busy_nxt_s = (busy_r & ~(rel_hit_s ? line_mask(rel_idx) : {NRES{1'b0}}))
               | ((win_found_s & ~win_oor_s) ? line_mask(win_idx_s) : {NRES{1'b0}});
    if (win_found_s) begin
      ptr_nxt_s = (win_id_s == PTR_W'(NREQ-1)) ? {PTR_W{1'b0}} : (win_id_s + PTR_W'(1));
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // State and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= {NRES{1'b0}};
      ptr_r       <= {PTR_W{1'b0}};
      enc_valid_r <= 1'b0;
      enc_idx_r   <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= {PTR_W{1'b0}};
      gnt_err_r   <= 1'b0;
      rel_err_r   <= 1'b0;
    end else begin
      busy_r      <= busy_nxt_s;
      ptr_r       <= ptr_nxt_s;
      enc_valid_r <= win_found_s & ~win_oor_s;
      if (win_found_s && !win_oor_s) begin
        enc_idx_r <= win_idx_s;
      end
      gnt_valid_r <= win_found_s;
      if (win_found_s) begin
        gnt_id_r <= win_id_s;
      end
      gnt_err_r   <= win_found_s & win_oor_s;
      rel_err_r   <= rel_valid & ~rel_hit_s;
    end
  end

  assign busy         = busy_r;
  assign enc_in_valid = enc_valid_r;
  assign enc_in       = enc_idx_r;
  assign gnt_valid    = gnt_valid_r;
  assign gnt_id       = gnt_id_r;
  assign gnt_err      = gnt_err_r;
  assign rel_err      = rel_err_r;

endmodule
